// File: rtl/alu_pkg.sv
// Shared types for the ALU result collector: IRQ FSM states, the FIFO entry
// layout, and the ALU data width.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    WAIT
  } irq_state_e;

  typedef struct packed {
    logic              irq;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a show-ahead head. A pop is only honoured when
// non-empty, and a push is only honoured when not full or popping in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_result_collector.sv
// Captures ALU results one cycle after alu_enable into a tagged FIFO, and
// services the ALU interrupt with a clear pulse that retries while it stays high.
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int CLR_RETRY = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_enable,
  input  logic [DATA_W-1:0]      alu_out,
  input  logic                   alu_irq,
  output logic                   alu_irq_clr,
  input  logic                   rd_en,
  output logic [ENTRY_W-1:0]     rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   ovf_clr,
  output logic [7:0]             irq_count
);

  localparam int RW = $clog2(CLR_RETRY) + 1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic       en_d1_q;
  logic       overflow_q, overflow_d;
  logic       capture, drop;
  entry_t     wr_entry;

  irq_state_e    state_q, state_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    irq_count_q, irq_count_d;
  logic          alu_irq_clr_q;

  // Capture path: the result is valid the cycle after the enable.
  assign capture        = en_d1_q;
  assign drop           = capture & full & ~rd_en;
  assign wr_entry.irq   = alu_irq;
  assign wr_entry.data  = alu_out;
  assign overflow_d     = (overflow_q & ~ovf_clr) | drop;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (capture),
    .wdata_i (wr_entry),
    .pop_i   (rd_en),
    .rdata_o (rd_data),
    .empty_o (empty),
    .full_o  (full),
    .count_o (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d1_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      en_d1_q    <= alu_enable;
      overflow_q <= overflow_d;
    end
  end

  // IRQ servicing: WAIT lasts CLR_RETRY cycles before re-pulsing.
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    irq_count_d = irq_count_q;
    case (state_q)
      IDLE: begin
        if (alu_irq) begin
          state_d     = CLEAR;
          irq_count_d = sat_inc8(irq_count_q);
        end
      end
      CLEAR: begin
        state_d = WAIT;
        retry_d = '0;
      end
      WAIT: begin
        if (!alu_irq) begin
          state_d = IDLE;
        end else if (retry_q == RW'(CLR_RETRY - 1)) begin
          state_d = CLEAR;
        end else begin
          retry_d = retry_q + RW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      retry_q       <= '0;
      irq_count_q   <= 8'h00;
      alu_irq_clr_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      retry_q       <= retry_d;
      irq_count_q   <= irq_count_d;
      alu_irq_clr_q <= (state_d == CLEAR);
    end
  end

  assign alu_irq_clr = alu_irq_clr_q;
  assign overflow    = overflow_q;
  assign irq_count   = irq_count_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// Bench for alu_result_collector: directed vector table, IRQ sequences,
// randomized traffic against a queue-based FIFO model, and mid-run reset.
module tb_alu_result_collector;

  localparam int DEPTH     = 8;
  localparam int CLR_RETRY = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alu_enable;
  logic [7:0] alu_out;
  logic       alu_irq;
  logic       alu_irq_clr;
  logic       rd_en;
  logic [8:0] rd_data;
  logic       empty, full;
  logic [3:0] count;
  logic       overflow;
  logic       ovf_clr;
  logic [7:0] irq_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [8:0] mq[$];
  logic       m_en;
  logic       m_ovf;

  typedef struct {
    logic       en;
    logic [7:0] o;
    logic       irq;
    logic       rd;
    logic       oc;
    int         cnt;
    logic [8:0] rdd;
    logic       ovf;
  } vec_t;

  vec_t tbl[28];

  alu_result_collector #(
    .DEPTH     (DEPTH),
    .CLR_RETRY (CLR_RETRY)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_enable  (alu_enable),
    .alu_out     (alu_out),
    .alu_irq     (alu_irq),
    .alu_irq_clr (alu_irq_clr),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
    .irq_count   (irq_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_en  = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_compare();
    logic [8:0] head;
    head = (mq.size() > 0) ? mq[0] : 9'h000;
    chk("model count",    32'(count),    32'(mq.size()));
    chk("model empty",    32'(empty),    32'(mq.size() == 0));
    chk("model full",     32'(full),     32'(mq.size() == DEPTH));
    chk("model rd_data",  32'(rd_data),  32'(head));
    chk("model overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Called at a falling edge; applies inputs for one rising edge and checks at the next falling edge.
  task automatic cyc(input logic en, input logic [7:0] o, input logic irq,
                     input logic rd, input logic oc);
    int         sz;
    logic       drop;
    logic [8:0] dummy;
    alu_enable = en;
    alu_out    = o;
    alu_irq    = irq;
    rd_en      = rd;
    ovf_clr    = oc;
    @(posedge clk);
    sz   = mq.size();
    drop = 1'b0;
    if (rd && sz > 0) dummy = mq.pop_front();
    if (m_en) begin
      if (sz == DEPTH && !rd) drop = 1'b1;
      else mq.push_back({irq, o});
    end
    m_ovf = (m_ovf && !oc) || drop;
    m_en  = en;
    @(negedge clk);
    model_compare();
  endtask

  initial begin
    int base;
    int k;

    rst_n = 1'b0; alu_enable = 1'b0; alu_out = 8'h00; alu_irq = 1'b0;
    rd_en = 1'b0; ovf_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset count",     32'(count),       32'd0);
    chk("reset empty",     32'(empty),       32'd1);
    chk("reset full",      32'(full),        32'd0);
    chk("reset overflow",  32'(overflow),    32'd0);
    chk("reset irq_count", 32'(irq_count),   32'd0);
    chk("reset irq_clr",   32'(alu_irq_clr), 32'd0);
    chk("reset rd_data",   32'(rd_data),     32'h000);
    rst_n = 1'b1;

    // Directed vectors: single capture/pop, fill past full, full push+pop, drain, tagging
    tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 0, 9'h000, 1'b0};
    tbl[1]  = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1, 9'h03C, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 9'h000, 1'b0};
    tbl[3]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 0, 9'h000, 1'b0};
    for (int i = 4; i <= 11; i++)
      tbl[i] = '{1'b1, 8'(i - 3), 1'b0, 1'b0, 1'b0, i - 3, 9'h001, 1'b0};
    tbl[12] = '{1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 8, 9'h001, 1'b1};
    tbl[13] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8, 9'h001, 1'b0};
    tbl[14] = '{1'b0, 8'hAA, 1'b0, 1'b1, 1'b0, 8, 9'h002, 1'b0};
    for (int i = 15; i <= 20; i++)
      tbl[i] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 22 - i, 9'(i - 12), 1'b0};
    tbl[21] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1, 9'h0AA, 1'b0};
    tbl[22] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 9'h000, 1'b0};
    tbl[23] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 9'h000, 1'b0};
    tbl[24] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 0, 9'h000, 1'b0};
    tbl[25] = '{1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1, 9'h15A, 1'b0};
    tbl[26] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 9'h000, 1'b0};
    tbl[27] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 9'h000, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 28; i++) begin
      cyc(tbl[i].en, tbl[i].o, tbl[i].irq, tbl[i].rd, tbl[i].oc);
      chk($sformatf("vec%0d count", i),    32'(count),    32'(tbl[i].cnt));
      chk($sformatf("vec%0d rd_data", i),  32'(rd_data),  32'(tbl[i].rdd));
      chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(tbl[i].ovf));
      chk($sformatf("vec%0d full", i),     32'(full),     32'(tbl[i].cnt == DEPTH));
    end
    repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Single interrupt that drops shortly after the clear pulse
    base = int'(irq_count);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00, (i < 3), 1'b0, 1'b0);
      chk($sformatf("single irq_clr c%0d", i), 32'(alu_irq_clr), 32'(i == 0));
    end
    chk("single irq_count", 32'(irq_count), 32'(base + 1));
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("back to idle clr",   32'(alu_irq_clr), 32'd1);
    chk("back to idle count", 32'(irq_count),   32'(base + 2));
    repeat (4) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Interrupt held 12 cycles, with rd_en on an empty FIFO throughout
    base = int'(irq_count);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, (i < 12), 1'b1, 1'b0);
      chk($sformatf("retry irq_clr c%0d", i), 32'(alu_irq_clr),
          32'((i < 12) && (i % (CLR_RETRY + 1) == 0)));
    end
    chk("retry irq_count", 32'(irq_count), 32'(base + 1));

    // Saturation of the service counter
    for (int i = 0; i < 260; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    chk("irq_count saturated", 32'(irq_count), 32'hFF);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
    end

    // Reset in the middle of operation: five entries queued, FSM in WAIT
    repeat (10) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h44, 1'b0, 1'b0, 1'b0);
    chk("pre-reset count", 32'(count), 32'd5);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    alu_enable = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async reset count",     32'(count),       32'd0);
    chk("async reset empty",     32'(empty),       32'd1);
    chk("async reset irq_clr",   32'(alu_irq_clr), 32'd0);
    chk("async reset irq_count", 32'(irq_count),   32'd0);
    chk("async reset rd_data",   32'(rd_data),     32'h000);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("post-reset edge1 count", 32'(count), 32'd0);
    cyc(1'b0, 8'h77, 1'b0, 1'b0, 1'b0);
    chk("post-reset edge2 count",   32'(count),   32'd1);
    chk("post-reset edge2 rd_data", 32'(rd_data), 32'h077);
    k = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_collector.md
ALU_RESULT_COLLECTOR -- requirements
Module: alu_result_collector

Interface
REQ-001 Parameter DEPTH, default 8, number of FIFO entries (power of two, 2..64) SHALL apply.
REQ-002 Parameter CLR_RETRY, default 4, cycles in WAIT before alu_irq_clr is re-pulsed, SHALL apply.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 alu_enable  input  1  ALU enable as driven to the ALU; marks an issued operation.
REQ-006 alu_out  input  8  ALU result.
REQ-007 alu_irq  input  1  ALU interrupt request, level.
REQ-008 alu_irq_clr  output  1  interrupt clear pulse to the ALU.
REQ-009 rd_en  input  1  consumer pop request.
REQ-010 rd_data  output  9  head entry, show-ahead: bit8 = irq tag, bits7:0 = result.
REQ-011 empty / full  output  1 each  FIFO status.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 overflow  output  1  sticky: a capture was dropped while full.
REQ-014 ovf_clr  input  1  clears overflow.
REQ-015 irq_count  output  8  number of interrupts serviced, saturating.

Function
REQ-016 The block SHALL register alu_enable into en_d1; a capture SHALL occur in the cycle en_d1=1 (ALU result latency one cycle).
REQ-017 A capture SHALL write {alu_irq, alu_out} sampled in that cycle to the FIFO tail.
REQ-018 rd_data SHALL show the head entry combinationally from storage, and 9'h000 when empty.
REQ-019 rd_en=1 with empty=0 SHALL pop the head at the clock edge; rd_en=1 with empty=1 SHALL be ignored (no pointer or count change).
REQ-020 Capture with full=1 and rd_en=0 SHALL be dropped and SHALL set overflow.
REQ-021 Capture with full=1 and rd_en=1 SHALL pop and push in the same cycle; count unchanged; no overflow.
REQ-022 Simultaneous push and pop when not full/empty SHALL leave count unchanged.
REQ-023 Pointers SHALL wrap modulo DEPTH; full when count=DEPTH, empty when count=0.
REQ-024 ovf_clr=1 SHALL clear overflow; if a drop occurs in the same cycle, overflow SHALL remain set (set wins).
REQ-025 IRQ FSM states IDLE, CLEAR, WAIT SHALL be implemented.
REQ-026 IDLE -> CLEAR when alu_irq=1; irq_count increments by 1 on this transition, saturating at 8'hFF.
REQ-027 CLEAR SHALL assert alu_irq_clr for exactly one cycle, then go to WAIT.
REQ-028 WAIT -> IDLE when alu_irq=0; if alu_irq stays 1 for CLR_RETRY cycles in WAIT, -> CLEAR (re-pulse, no irq_count increment).
REQ-029 alu_irq_clr SHALL be registered and asserted only in CLEAR.
REQ-030 FIFO path and IRQ FSM SHALL operate independently; irq tagging uses the raw alu_irq level.

Reset
REQ-031 On rst_n=0 asynchronously: pointers, count=0, empty=1, full=0, overflow=0, irq_count=0, en_d1=0, FSM=IDLE, alu_irq_clr=0, rd_data=9'h000.
REQ-032 Reset mid-operation SHALL discard all FIFO contents and any pending capture; storage array need not be reset.
REQ-033 First capture possible on the second rising edge after rst_n deasserts with alu_enable=1.

Structure
REQ-034 Package alu_pkg SHALL hold the FSM state enum (IDLE, CLEAR, WAIT), the result entry typedef (irq bit + 8-bit data), and the ALU data-width constant 8.
REQ-035 FIFO storage/pointers SHALL be a sub-module sync_fifo (parameterised width, depth); FSM and capture logic stay in the top.

Verification
REQ-036 alu_enable=1 one cycle, alu_out=8'h3C next cycle, alu_irq=0 -> count=1, rd_data=9'h03C; rd_en pop -> empty=1, rd_data=9'h000.
REQ-037 Nine consecutive captures 8'h01..8'h09, DEPTH=8, no reads -> full=1, count=8, overflow=1, head=9'h001; ovf_clr -> overflow=0.
REQ-038 Full FIFO, capture 8'hAA with rd_en=1 -> count stays 8, overflow=0, head advances to 9'h002, 8'hAA at tail.
REQ-039 alu_irq rises and drops 2 cycles after alu_irq_clr -> exactly one 1-cycle alu_irq_clr, irq_count=1, FSM back to IDLE.
REQ-040 alu_irq held high 12 cycles -> alu_irq_clr re-pulsed every CLR_RETRY+1 cycles, irq_count=1; rd_en on empty -> no change.
REQ-041 rst_n asserted with count=5 and FSM=WAIT -> immediately count=0, empty=1, alu_irq_clr=0, irq_count=0.
